// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: sequential PC generation, one outstanding read, DEPTH-entry prefetch FIFO.
// Optional same-cycle response bypass to decode when FETCH_BYPASS_EN is defined.
module fetch_prefetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    output logic [3:0]  imem_wmask,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pend_pc_q, pend_pc_d;
    logic          outstanding_q, outstanding_d;
    logic          discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] fifo_pc_q    [DEPTH];
    logic [31:0] fifo_instr_q [DEPTH];

    logic [CW:0]  credit;
    logic         want;
    logic         issue;
    logic         resp_v;
    logic         accept;
    logic         bypass;
    logic         push;
    logic         pop;
    logic         fifo_empty;
    logic [31:0]  issue_pc;

    assign imem_wmask = 4'h0;
    assign imem_wdata = 32'h0;

    // Credit check uses registered occupancy only; an in-flight pop is not counted.
    assign credit     = {1'b0, count_q} + {{CW{1'b0}}, outstanding_q};
    assign want       = rst_n && (credit < (CW+1)'(DEPTH));
    assign issue_pc   = redirect_valid ? redirect_pc : fetch_pc_q;
    assign issue      = want && (!outstanding_q || imem_resp);
    assign resp_v     = imem_resp && outstanding_q;
    assign accept     = resp_v && !discard_q && !redirect_valid;
    assign fifo_empty = (count_q == '0);

    assign imem_rmask = want ? 4'hF : 4'h0;
    assign imem_addr  = issue_pc;

`ifdef FETCH_BYPASS_EN
    assign bypass = accept && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !fifo_empty || bypass;
    assign out_pc    = bypass ? pend_pc_q  : fifo_pc_q[rd_ptr_q];
    assign out_instr = bypass ? imem_rdata : fifo_instr_q[rd_ptr_q];

    // A bypassed word consumed by decode this cycle never enters the FIFO.
    assign push = accept && !(bypass && out_ready);
    assign pop  = !fifo_empty && out_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        pend_pc_d     = pend_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (issue) begin
            pend_pc_d     = issue_pc;
            fetch_pc_d    = issue_pc + 32'd4;
            outstanding_d = 1'b1;
        end else begin
            if (redirect_valid) begin
                fetch_pc_d = redirect_pc;
            end
            if (resp_v) begin
                outstanding_d = 1'b0;
            end
        end

        // The memory cannot cancel a request, so its late response must be dropped.
        if (resp_v) begin
            discard_d = 1'b0;
        end
        if (redirect_valid && outstanding_q && !imem_resp) begin
            discard_d = 1'b1;
        end

        if (redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            pend_pc_q     <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            pend_pc_q     <= pend_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    fifo_pc_q[gi]    <= pend_pc_q;
                    fifo_instr_q[gi] <= imem_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit: a latency-programmable memory drives the DUT and a
// queue-based model of the fetch stream predicts the port and decode outputs every cycle.
module tb_fetch_prefetch_unit;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;
    localparam int          DEPTH    = 4;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_OUT = 1;
`else
    localparam int FIRST_OUT = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [3:0]  imem_wmask;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    fetch_prefetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_wmask     (imem_wmask),
        .imem_wdata     (imem_wdata),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // memory model state
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          wait_min;
    int          wait_max;

    // reference model: fetch stream as a queue of PCs plus the single in-flight request
    logic [31:0] m_q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_pend;
    bit          m_outst;
    bit          m_stale;

    // last observations
    bit          obs_valid;
    logic [31:0] obs_pc;
    logic [3:0]  obs_rmask;
    bit          last_cap;
    logic [31:0] last_cap_addr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a3c96e1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fpc    = RESET_PC;
        m_pend   = RESET_PC;
        m_outst  = 1'b0;
        m_stale  = 1'b0;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        mem_addr = '0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        imem_resp      = 1'b0;
        imem_rdata     = '0;
        #1;
        check_eq("rst_rmask", 32'(imem_rmask), 32'h0);
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: called at a falling edge, returns at the next falling edge.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
        bit          want;
        bit          acc;
        bit          ev;
        bit          cap;
        bit          mcap;
        bit          consumed;
        logic [31:0] epc;
        logic [31:0] ipc;
        logic [31:0] dummy;

        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        imem_resp      = mem_busy && (mem_cnt == 0);
        imem_rdata     = imem_resp ? mem_word(mem_addr) : $urandom();
        #1;

        want = (m_q.size() + int'(m_outst)) < DEPTH;
        acc  = imem_resp && m_outst && !m_stale && !rv;
        ev   = 1'b0;
        epc  = '0;
        if (m_q.size() > 0) begin
            ev  = 1'b1;
            epc = m_q[0];
        end
`ifdef FETCH_BYPASS_EN
        else if (acc) begin
            ev  = 1'b1;
            epc = m_pend;
        end
`endif
        ipc = rv ? rpc : m_fpc;

        check_eq("rmask", 32'(imem_rmask), want ? 32'hF : 32'h0);
        if (want) check_eq("addr", imem_addr, ipc);
        check_eq("out_valid", 32'(out_valid), 32'(ev));
        if (ev && out_valid) begin
            check_eq("out_pc", out_pc, epc);
            check_eq("out_instr", out_instr, mem_word(epc));
        end
        if (out_valid && rdy && !rv)
            $display("[%0t] decode pc=%h instr=%h", $time, out_pc, out_instr);

        obs_valid = out_valid;
        obs_pc    = out_pc;
        obs_rmask = imem_rmask;

        // memory reacts to what the DUT actually presents
        cap      = (imem_rmask == 4'hF) && (!mem_busy || imem_resp);
        last_cap = cap;
        if (cap) last_cap_addr = imem_addr;
        if (imem_resp) mem_busy = 1'b0;
        if (cap) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = int'($urandom_range(wait_max, wait_min));
        end else if (mem_busy && mem_cnt > 0) begin
            mem_cnt--;
        end

        // advance the reference model
        mcap = want && (!m_outst || imem_resp);
        if (rv) begin
            m_q.delete();
        end else begin
            consumed = 1'b0;
            if (ev && rdy) begin
                if (m_q.size() > 0) dummy = m_q.pop_front();
                else consumed = 1'b1;
            end
            if (acc && !consumed) m_q.push_back(m_pend);
        end
        if (imem_resp) m_stale = 1'b0;
        if (rv && m_outst && !imem_resp) m_stale = 1'b1;
        if (mcap) begin
            m_pend  = ipc;
            m_outst = 1'b1;
            m_fpc   = ipc + 32'd4;
        end else begin
            if (imem_resp) m_outst = 1'b0;
            if (rv) m_fpc = rpc;
        end

        @(negedge clk);
    endtask

    task automatic random_phase(input int n, input int wmin, input int wmax,
                                input int rv_pct, input int rdy_pct, input int rst_at);
        logic [31:0] r;
        bit          rv;
        bit          rdy;
        wait_min = wmin;
        wait_max = wmax;
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) do_reset();
            rv  = ($urandom_range(99, 0) < rv_pct);
            rdy = ($urandom_range(99, 0) < rdy_pct);
            r   = $urandom();
            r[1:0] = 2'b00;
            if ($urandom_range(7, 0) == 0) r = 32'hFFFFFFF8;
            step(rv, r, rdy);
        end
    endtask

    initial begin
        bit found;
        rst_n    = 1'b0;
        wait_min = 0;
        wait_max = 0;
        last_cap = 1'b0;
        last_cap_addr = '0;
        do_reset();

        // zero-wait streaming: first decode word is RESET_PC
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (i == FIRST_OUT) begin
                check_eq("first_valid", 32'(obs_valid), 32'h1);
                check_eq("first_pc", obs_pc, RESET_PC);
            end
        end

        // decode stall fills the FIFO then stops requesting
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
        check_eq("stall_rmask", 32'(obs_rmask), 32'h0);
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);

        // 5-cycle memory, redirect two cycles after RESET_PC+8 is issued
        do_reset();
        wait_min = 4;
        wait_max = 4;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (last_cap && last_cap_addr == RESET_PC + 32'd8) found = 1'b1;
        end
        check_eq("find_issue_008", 32'(found), 32'h1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h1eceb100, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (obs_valid) found = 1'b1;
        end
        check_eq("post_redirect_seen", 32'(found), 32'h1);
        check_eq("post_redirect_pc", obs_pc, 32'h1eceb100);

        // randomized mixes of latency, redirects and backpressure
        random_phase(300, 0, 0, 10, 70, -1);
        random_phase(300, 0, 3, 15, 50, -1);
        random_phase(200, 0, 6, 5, 90, -1);
        random_phase(200, 2, 5, 25, 30, -1);
        // reset asserted while a long request is pending
        random_phase(60, 6, 6, 5, 80, 20);
        random_phase(200, 0, 2, 10, 60, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
